// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM-subset core: NZCV bit positions, datapath
// defaults and the EXE_CMD encodings produced by the decoder.
package cpu_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 4;

  localparam int STATUS_N = 3;
  localparam int STATUS_Z = 2;
  localparam int STATUS_C = 1;
  localparam int STATUS_V = 0;

  // Several mnemonics share an ALU op (CMP=SUB, TST=AND, LDR/STR=ADD), so these
  // are plain constants rather than an enum.
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_CMP = 4'b0100;
  localparam logic [3:0] EXE_TST = 4'b0110;
  localparam logic [3:0] EXE_LDR = 4'b0010;
  localparam logic [3:0] EXE_STR = 4'b0010;

endpackage

// File: rtl/status_register.sv
// Architectural NZCV storage: whole-nibble write with enable, synchronous reset.
module status_register (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= 4'b0000;
    else if (we) q <= d;
  end

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register with NZCV status register, freeze/flush control
// and a saturating stall-cycle counter.
module exe_mem_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  s_bit_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0]     alu_res_in,
  input  logic [DATA_W-1:0]     st_val_in,
  input  logic [3:0]            status_in,
  output logic                  valid_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [DATA_W-1:0]     alu_res_out,
  output logic [DATA_W-1:0]     st_val_out,
  output logic [3:0]            status_reg,
  output logic                  carry_out,
  output logic [CNT_W-1:0]      stall_cycles
);

  logic status_we;

  // Flags only move for a live S-instruction that actually advances.
  assign status_we = valid_in & s_bit_in & ~freeze & ~flush;

  status_register u_status (
    .clk (clk),
    .rst (rst),
    .we  (status_we),
    .d   (status_in),
    .q   (status_reg)
  );

  assign carry_out = status_reg[STATUS_C];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out    <= 1'b0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      st_val_out   <= '0;
      stall_cycles <= '0;
    end else if (freeze) begin
      if (stall_cycles != {CNT_W{1'b1}}) stall_cycles <= stall_cycles + 1'b1;
    end else if (flush) begin
      valid_out    <= 1'b0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      st_val_out   <= '0;
    end else begin
      // Control bits are gated by valid so a dead slot never writes anything.
      valid_out    <= valid_in;
      wb_en_out    <= wb_en_in & valid_in;
      mem_r_en_out <= mem_r_en_in & valid_in;
      mem_w_en_out <= mem_w_en_in & valid_in;
      dest_out     <= dest_in;
      alu_res_out  <= alu_res_in;
      st_val_out   <= st_val_in;
    end
  end

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Bench for exe_mem_stage_reg: behavioural model + per-cycle compare, plus
// literal checks of the directed scenarios. A second instance uses a 3-bit counter.
module tb_exe_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_bit_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in, st_val_in;
  logic [3:0]  status_in;

  logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, carry_out;
  logic [3:0]  dest_out, status_reg;
  logic [31:0] alu_res_out, st_val_out;
  logic [15:0] stall_cycles;

  logic        s_valid_out, s_wb_en_out, s_mem_r_en_out, s_mem_w_en_out, s_carry_out;
  logic [3:0]  s_dest_out, s_status_reg;
  logic [31:0] s_alu_res_out, s_st_val_out;
  logic [2:0]  s_stall_cycles;

  always #5 clk = ~clk;

  exe_mem_stage_reg u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_bit_in(s_bit_in), .dest_in(dest_in), .alu_res_in(alu_res_in),
    .st_val_in(st_val_in), .status_in(status_in), .valid_out(valid_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .dest_out(dest_out), .alu_res_out(alu_res_out), .st_val_out(st_val_out),
    .status_reg(status_reg), .carry_out(carry_out), .stall_cycles(stall_cycles)
  );

  exe_mem_stage_reg #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_bit_in(s_bit_in), .dest_in(dest_in), .alu_res_in(alu_res_in),
    .st_val_in(st_val_in), .status_in(status_in), .valid_out(s_valid_out),
    .wb_en_out(s_wb_en_out), .mem_r_en_out(s_mem_r_en_out), .mem_w_en_out(s_mem_w_en_out),
    .dest_out(s_dest_out), .alu_res_out(s_alu_res_out), .st_val_out(s_st_val_out),
    .status_reg(s_status_reg), .carry_out(s_carry_out), .stall_cycles(s_stall_cycles)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: what the stage must hold after each edge ----
  typedef struct {
    bit        v, wb, rd, wr;
    bit [3:0]  dest;
    bit [31:0] res, st;
  } slot_t;

  slot_t  m_slot;
  bit [3:0] m_flags;
  int     m_stalls;     // unbounded count of freeze cycles since reset
  bit     armed = 0;

  function automatic int sat(input int n, input int bits);
    int top = (1 << bits) - 1;
    return (n > top) ? top : n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_slot = '{default: 0};
      m_flags = 4'b0;
      m_stalls = 0;
      armed = 1;
    end else if (freeze) begin
      m_stalls = m_stalls + 1;
    end else if (flush) begin
      m_slot = '{default: 0};
    end else begin
      m_slot.v    = valid_in;
      m_slot.wb   = valid_in && wb_en_in;
      m_slot.rd   = valid_in && mem_r_en_in;
      m_slot.wr   = valid_in && mem_w_en_in;
      m_slot.dest = dest_in;
      m_slot.res  = alu_res_in;
      m_slot.st   = st_val_in;
      if (valid_in && s_bit_in) m_flags = status_in;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("valid",    64'(valid_out),    64'(m_slot.v));
      chk("wb_en",    64'(wb_en_out),    64'(m_slot.wb));
      chk("mem_r_en", 64'(mem_r_en_out), 64'(m_slot.rd));
      chk("mem_w_en", 64'(mem_w_en_out), 64'(m_slot.wr));
      chk("dest",     64'(dest_out),     64'(m_slot.dest));
      chk("alu_res",  64'(alu_res_out),  64'(m_slot.res));
      chk("st_val",   64'(st_val_out),   64'(m_slot.st));
      chk("status",   64'(status_reg),   64'(m_flags));
      chk("carry",    64'(carry_out),    64'(m_flags[1]));
      chk("stall16",  64'(stall_cycles), 64'(sat(m_stalls, 16)));
      chk("stall3",   64'(s_stall_cycles), 64'(sat(m_stalls, 3)));
      chk("sat_pipe", {s_valid_out, s_wb_en_out, s_mem_r_en_out, s_mem_w_en_out,
                       s_dest_out, s_status_reg, s_carry_out, s_alu_res_out[15:0]},
                      {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out,
                       dest_out, status_reg, carry_out, alu_res_out[15:0]});
    end
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit wb, input bit rd, input bit wr, input bit s,
                       input bit [3:0] d, input bit [31:0] res, input bit [31:0] st,
                       input bit [3:0] nzcv);
    valid_in = v; wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr; s_bit_in = s;
    dest_in = d; alu_res_in = res; st_val_in = st; status_in = nzcv;
  endtask

  initial begin
    rst = 1; freeze = 0; flush = 0;
    // 1: reset with busy inputs
    drive(1, 1, 1, 1, 1, 4'hF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'b1111);
    tick(); tick();
    chk("t1_valid",  64'(valid_out), 64'd0);
    chk("t1_alu",    64'(alu_res_out), 64'd0);
    chk("t1_status", 64'(status_reg), 64'd0);
    chk("t1_stall",  64'(stall_cycles), 64'd0);
    rst = 0;

    // 2: S-instruction writes flags, carry visible next cycle
    drive(1, 1, 0, 0, 1, 4'd3, 32'h0, 32'h11, 4'b0110);
    tick();
    chk("t2_status", 64'(status_reg), 64'h6);
    chk("t2_carry",  64'(carry_out), 64'd1);
    chk("t2_alu",    64'(alu_res_out), 64'd0);

    // 3: non-S instruction leaves flags alone
    drive(1, 1, 0, 0, 0, 4'd5, 32'h1234, 32'h22, 4'b1001);
    tick();
    chk("t3_status", 64'(status_reg), 64'h6);
    chk("t3_alu",    64'(alu_res_out), 64'h1234);
    chk("t3_dest",   64'(dest_out), 64'd5);

    // invalid slot with control bits set must not leak, load/store capture
    drive(0, 1, 1, 1, 1, 4'd7, 32'h77, 32'h88, 4'b0001);
    tick();
    chk("inv_wb", 64'(wb_en_out), 64'd0);
    chk("inv_st", 64'(status_reg), 64'h6);
    drive(1, 0, 0, 1, 0, 4'd2, 32'h100, 32'hABCD, 4'b0000);
    tick();
    chk("str_wr", 64'(mem_w_en_out), 64'd1);
    drive(1, 1, 1, 0, 0, 4'd9, 32'h104, 32'h0, 4'b0000);
    tick();

    // 4: freeze 3 cycles with moving inputs
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 1, 4'(i + 10), 32'h5000 + 32'(i), 32'h0, 4'b1000);
      tick();
    end
    chk("t4_hold_alu", 64'(alu_res_out), 64'h104);
    chk("t4_hold_st",  64'(status_reg), 64'h6);
    chk("t4_stall",    64'(stall_cycles), 64'd3);
    freeze = 0;
    tick();
    chk("t4_release",  64'(alu_res_out), 64'h5002);
    chk("t4_flags",    64'(status_reg), 64'h8);

    // 5: flush squashes an S-instruction
    flush = 1;
    drive(1, 1, 0, 0, 1, 4'd4, 32'h44, 32'h0, 4'b1000);
    drive(1, 1, 0, 0, 1, 4'd4, 32'h44, 32'h0, 4'b0011);
    tick();
    chk("t5_valid",  64'(valid_out), 64'd0);
    chk("t5_wb",     64'(wb_en_out), 64'd0);
    chk("t5_status", 64'(status_reg), 64'h8);
    flush = 0;
    drive(1, 1, 0, 0, 0, 4'd6, 32'h66, 32'h0, 4'b0000);
    tick();
    freeze = 1; flush = 1;
    drive(1, 1, 0, 0, 1, 4'd1, 32'h99, 32'h0, 4'b0101);
    tick(); tick();
    chk("t5_noflush", 64'(valid_out), 64'd1);
    chk("t5_hold",    64'(alu_res_out), 64'h66);

    // 6: 3-bit counter saturates, then reset mid-freeze
    flush = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_sat3",  64'(s_stall_cycles), 64'd7);
    chk("t6_cnt16", 64'(stall_cycles), 64'd9);
    rst = 1;
    tick();
    chk("t6_rst_valid", 64'(valid_out), 64'd0);
    chk("t6_rst_stall", 64'(stall_cycles), 64'd0);
    chk("t6_rst_sat",   64'(s_stall_cycles), 64'd0);
    rst = 0; freeze = 0;

    // mixed traffic under the model
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), $urandom, $urandom, 4'($urandom));
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 4) == 0);
      tick();
    end
    freeze = 0; flush = 0;
    tick();

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
